writeback_stage: RTL and testbench
==================================

# writeback_stage

Final stage of the ARM_Calculator pipeline and the write end of the register-file port that `Decode` reads. It accepts retiring instructions from the memory stage through a valid/ready handshake. For loads it waits for memory read data, with a timeout. It then drives the register-file write port (`Rd`, `WD3`, `WE3`). Writes to R15 become a PC redirect instead of a register write.

## Interface
- `DATA_W`, 32: datapath width.
- `MEM_TIMEOUT`, 15: maximum cycles spent waiting for `mem_rvalid` on a load (1..255).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m_valid`  in  1  memory stage presents an instruction.
- `m_ready`  out  1  stage accepts an instruction this cycle.
- `m_alu_result`  in  DATA_W  ALU result / address.
- `m_wa3`  in  4  destination register.
- `m_reg_write`  in  1  instruction writes a register.
- `m_mem_to_reg`  in  1  result comes from memory (load).
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  DATA_W  load data.
- `Rd`  out  4  register-file write address.
- `WD3`  out  DATA_W  register-file write data.
- `WE3`  out  1  register-file write enable.
- `pc_redirect`  out  1  one-cycle pulse: R15 written.
- `pc_target`  out  DATA_W  new PC value, valid with `pc_redirect`.
- `mem_timeout`  out  1  one-cycle pulse: load abandoned.
- `retired`  out  16  count of completed instructions.

## Operation
- **States:**
  - `IDLE`: no result pending.
  - `WAIT_MEM`: load outstanding.
  - `WRITE`: result being committed.
- **Readiness:** `m_ready` = 1 in `IDLE` and `WRITE`, 0 in `WAIT_MEM`.
- **Accept:** an instruction is accepted on a rising edge with `m_valid & m_ready`. At that edge it latches `m_wa3`, `m_reg_write`, `m_mem_to_reg` and `m_alu_result`.
  - Non-load: go to `WRITE` with result = `m_alu_result`.
  - Load: go to `WAIT_MEM` and clear the wait counter.
- **`WAIT_MEM`:**
  - Edge with `mem_rvalid` = 1: latch `mem_rdata` as the result, go to `WRITE`.
  - Otherwise the wait counter increments.
  - When the counter reaches `MEM_TIMEOUT`: go to `IDLE`, pulse `mem_timeout` for one cycle, perform no write, leave `retired` unchanged.
- **`WRITE` (exactly one cycle per instruction):**
  - If `reg_write` and destination ≠ 15: `WE3` = 1, `Rd` = destination, `WD3` = result.
  - If `reg_write` and destination = 15: `WE3` = 0, `pc_redirect` = 1, `pc_target` = result.
  - If `reg_write` = 0: no write and no redirect.
  - `retired` increments in all three cases and wraps from 0xFFFF to 0.
  - Next state: `WAIT_MEM` or `WRITE` if a new instruction is accepted in the same cycle, else `IDLE`.
- **Stray read data:** `mem_rvalid` outside `WAIT_MEM` is ignored.
- **Data width:** no width conversion; results pass through unmodified.

## Timing
- **Reset:** `rst_n` low asynchronously forces:
  - state `IDLE`, `m_ready` = 1;
  - `WE3`, `pc_redirect`, `mem_timeout` = 0;
  - `Rd` = 0, `WD3` = 0, `pc_target` = 0, `retired` = 0, wait counter = 0.
  - Reset mid-load discards the pending load without writing.
- **Non-load latency:** write asserted in the cycle after the accept edge. Sustained throughput is 1 instruction/cycle.
- **Load latency:** write asserted in the cycle after the edge that samples `mem_rvalid`.
  - `mem_rvalid` present in the first `WAIT_MEM` cycle gives 2-cycle latency from accept.
  - Timeout fires on the `MEM_TIMEOUT`-th edge spent in `WAIT_MEM`. `m_ready` returns to 1 in the same cycle as the `mem_timeout` pulse.
- **Registered outputs:** `WE3`, `pc_redirect` and `mem_timeout` are registered.
- **Write timing at the register file:** the register file captures `WD3` on the edge ending the `WRITE` cycle, so `Decode` sees the new value one cycle after `WE3` is asserted.

## Structure
- **Package `arm_wb_pkg`:**
  - state enum (`IDLE`, `WAIT_MEM`, `WRITE`);
  - `REG_PC` = 4'd15;
  - `DATA_W` default.
- **Sub-module `mem_wait_timer`:** the one natural sub-module. It holds the wait counter with clear, enable and `expired` output, and shares `clk`/`rst_n` with the parent.
- **Top level:** FSM, result register, write-port drivers and the `retired` counter stay in `writeback_stage`.

## Test plan
- **ALU write:** accept {wa3=1, reg_write=1, alu=555} → next cycle `WE3`=1, `Rd`=1, `WD3`=555; `retired`=1; `Decode` then reads 555 from R1.
- **Back-to-back:** `m_valid` held for 3 cycles with wa3=5,7,2 → `WE3` high 3 consecutive cycles, `m_ready` never drops, `retired`=3.
- **Load:** accept {wa3=7, mem_to_reg=1, alu=0x40}, `mem_rvalid` with 666 after 3 cycles → `m_ready` low for 3 cycles, then `WE3`=1, `Rd`=7, `WD3`=666.
- **Load timeout:** load with `mem_rvalid` never asserted, `MEM_TIMEOUT`=15 → `mem_timeout` pulses after 15 cycles, `WE3` stays 0, `retired` unchanged, `m_ready`=1.
- **R15 write:** accept {wa3=15, reg_write=1, alu=0x100} → `pc_redirect`=1 and `pc_target`=0x100 for one cycle, `WE3`=0.
- **Reset mid-load:** reset during `WAIT_MEM`, then a stray `mem_rvalid` → no write, all outputs at reset values, `retired`=0.

Source files
------------

// File: rtl/arm_wb_pkg.sv
// Shared types and constants for the ARM_Calculator writeback stage.
package arm_wb_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned REG_W      = 4;
   localparam int unsigned RET_W      = 16;
   localparam int unsigned TMR_W      = 8;

   localparam logic [REG_W-1:0] REG_PC = 4'd15;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } wb_state_e;

   // Destination info held across a load wait.
   typedef struct packed {
      logic [REG_W-1:0] wa3;
      logic             reg_write;
   } wb_dest_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on load data; flags the last allowed cycle.
module mem_wait_timer
   import arm_wb_pkg::*;
#(
   parameter int unsigned LIMIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_c
);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   // Expired means the coming edge is the LIMIT-th one spent waiting.
   assign expired_c = (cnt_q == TMR_W'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_c) begin
         cnt_d = cnt_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits ALU/load results to the register file or
// redirects the PC on R15 writes; abandons loads whose data never arrives.
module writeback_stage
   import arm_wb_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m_valid,
   output logic              m_ready,
   input  logic [DATA_W-1:0] m_alu_result,
   input  logic [REG_W-1:0]  m_wa3,
   input  logic              m_reg_write,
   input  logic              m_mem_to_reg,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [REG_W-1:0]  Rd,
   output logic [DATA_W-1:0] WD3,
   output logic              WE3,
   output logic              pc_redirect,
   output logic [DATA_W-1:0] pc_target,
   output logic              mem_timeout,
   output logic [RET_W-1:0]  retired
);

   wb_state_e state_q, state_d;
   wb_dest_t  dest_q, dest_d;

   logic [REG_W-1:0]  rd_q, rd_d;
   logic [DATA_W-1:0] wd3_q, wd3_d;
   logic [DATA_W-1:0] tgt_q, tgt_d;
   logic [RET_W-1:0]  retired_q, retired_d;
   logic              we3_q, we3_d;
   logic              redir_q, redir_d;
   logic              tmo_q, tmo_d;

   logic              accept_c;
   logic              load_acc_c;
   logic              rvalid_c;
   logic              tmo_c;
   logic              expired_c;
   logic              commit_c;
   wb_dest_t          commit_dest_c;
   logic [DATA_W-1:0] commit_data_c;

   assign m_ready    = (state_q != WAIT_MEM);
   assign accept_c   = m_valid && m_ready;
   assign load_acc_c = accept_c && m_mem_to_reg;
   assign rvalid_c   = (state_q == WAIT_MEM) && mem_rvalid;
   assign tmo_c      = (state_q == WAIT_MEM) && !mem_rvalid && expired_c;

   // A result is committed either straight from an accepted non-load or from load data.
   assign commit_c      = (accept_c && !m_mem_to_reg) || rvalid_c;
   assign commit_dest_c = rvalid_c ? dest_q : wb_dest_t'({m_wa3, m_reg_write});
   assign commit_data_c = rvalid_c ? mem_rdata : m_alu_result;

   mem_wait_timer #(
      .LIMIT (MEM_TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (load_acc_c),
      .en_i      (state_q == WAIT_MEM),
      .expired_c (expired_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, WRITE: begin
            if (accept_c) begin
               state_d = m_mem_to_reg ? WAIT_MEM : WRITE;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_MEM: begin
            if (mem_rvalid) begin
               state_d = WRITE;
            end else if (expired_c) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values for the registered write-port, redirect and status outputs.
   always_comb begin
      we3_d     = 1'b0;
      redir_d   = 1'b0;
      tmo_d     = tmo_c;
      rd_d      = rd_q;
      wd3_d     = wd3_q;
      tgt_d     = tgt_q;
      retired_d = retired_q;
      dest_d    = dest_q;
      if (load_acc_c) begin
         dest_d.wa3       = m_wa3;
         dest_d.reg_write = m_reg_write;
      end
      if (commit_c) begin
         retired_d = retired_q + RET_W'(1);
         if (commit_dest_c.reg_write) begin
            if (commit_dest_c.wa3 == REG_PC) begin
               redir_d = 1'b1;
               tgt_d   = commit_data_c;
            end else begin
               we3_d = 1'b1;
               rd_d  = commit_dest_c.wa3;
               wd3_d = commit_data_c;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dest_q    <= '0;
         rd_q      <= '0;
         wd3_q     <= '0;
         tgt_q     <= '0;
         retired_q <= '0;
         we3_q     <= 1'b0;
         redir_q   <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         dest_q    <= dest_d;
         rd_q      <= rd_d;
         wd3_q     <= wd3_d;
         tgt_q     <= tgt_d;
         retired_q <= retired_d;
         we3_q     <= we3_d;
         redir_q   <= redir_d;
         tmo_q     <= tmo_d;
      end
   end

   assign Rd          = rd_q;
   assign WD3         = wd3_q;
   assign WE3         = we3_q;
   assign pc_redirect = redir_q;
   assign pc_target   = tgt_q;
   assign mem_timeout = tmo_q;
   assign retired     = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: driver predicts commits, monitor checks them.
module tb_writeback_stage;

   localparam int unsigned DW = 32;
   localparam int unsigned T  = 15;

   logic          clk;
   logic          rst_n;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_alu_result;
   logic [3:0]    m_wa3;
   logic          m_reg_write;
   logic          m_mem_to_reg;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic [3:0]    Rd;
   logic [DW-1:0] WD3;
   logic          WE3;
   logic          pc_redirect;
   logic [DW-1:0] pc_target;
   logic          mem_timeout;
   logic [15:0]   retired;

   writeback_stage #(.DATA_W(DW), .MEM_TIMEOUT(T)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_alu_result (m_alu_result),
      .m_wa3        (m_wa3),
      .m_reg_write  (m_reg_write),
      .m_mem_to_reg (m_mem_to_reg),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .Rd           (Rd),
      .WD3          (WD3),
      .WE3          (WE3),
      .pc_redirect  (pc_redirect),
      .pc_target    (pc_target),
      .mem_timeout  (mem_timeout),
      .retired      (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // kind: 0 = register write, 1 = PC redirect, 2 = load timeout
   typedef struct {
      int          kind;
      logic [3:0]  rd;
      logic [31:0] data;
      logic [15:0] ret;
      longint      t;
   } ev_t;

   ev_t         exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] model_ret;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
   endtask

   task automatic push(input int kind, input logic [3:0] rd, input logic [31:0] d);
      ev_t e;
      e.kind = kind;
      e.rd   = rd;
      e.data = d;
      e.ret  = model_ret;
      e.t    = $time;
      exp_q.push_back(e);
   endtask

   // Expected outcome of one completed instruction, from the architectural rules.
   task automatic commit(input logic [3:0] wa3, input logic rw, input logic [31:0] d);
      model_ret = model_ret + 16'd1;
      if (rw) push((wa3 == 4'd15) ? 1 : 0, wa3, d);
   endtask

   // d = cycles without data before mem_rvalid; d >= T means data never comes.
   task automatic do_instr(input logic [3:0] wa3, input logic rw, input logic mtr,
                           input logic [31:0] alu, input int d, input logic [31:0] rdata);
      @(negedge clk);
      m_valid      = 1'b1;
      m_wa3        = wa3;
      m_reg_write  = rw;
      m_mem_to_reg = mtr;
      m_alu_result = alu;
      mem_rvalid   = 1'($urandom_range(0, 1));
      mem_rdata    = $urandom;
      chk("m_ready_at_accept", 32'(m_ready), 32'd1);
      @(posedge clk);
      if (!mtr) begin
         commit(wa3, rw, alu);
      end else begin
         for (int k = 1; k <= int'(T); k++) begin
            @(negedge clk);
            m_valid    = 1'b0;
            mem_rvalid = 1'b0;
            chk("m_ready_in_wait", 32'(m_ready), 32'd0);
            if (d < int'(T) && k == d + 1) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rdata;
               @(posedge clk);
               commit(wa3, rw, rdata);
               break;
            end
            @(posedge clk);
            if (k == int'(T)) push(2, 4'd0, 32'd0);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         m_valid    = 1'b0;
         mem_rvalid = 1'($urandom_range(0, 1));
         mem_rdata  = $urandom;
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_m_ready", 32'(m_ready), 32'd1);
      chk("rst_WE3", 32'(WE3), 32'd0);
      chk("rst_pc_redirect", 32'(pc_redirect), 32'd0);
      chk("rst_mem_timeout", 32'(mem_timeout), 32'd0);
      chk("rst_Rd", 32'(Rd), 32'd0);
      chk("rst_WD3", WD3, 32'd0);
      chk("rst_pc_target", pc_target, 32'd0);
      chk("rst_retired", 32'(retired), 32'd0);
   endtask

   // Monitor: every write/redirect/timeout pulse must match the next expectation.
   int  nset;
   int  gotk;
   ev_t me;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            nset = int'(WE3) + int'(pc_redirect) + int'(mem_timeout);
            if (nset > 1) begin
               chk("pulses_exclusive", 32'(nset), 32'd1);
            end else if (nset == 1) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_event", 32'd1, 32'd0);
               end else begin
                  me   = exp_q.pop_front();
                  gotk = WE3 ? 0 : (pc_redirect ? 1 : 2);
                  chk("event_kind", 32'(gotk), 32'(me.kind));
                  chk("event_latency", 32'($time - me.t), 32'd5);
                  if (me.kind == 0 && gotk == 0) begin
                     chk("Rd", 32'(Rd), 32'(me.rd));
                     chk("WD3", WD3, me.data);
                  end
                  if (me.kind == 1 && gotk == 1) chk("pc_target", pc_target, me.data);
                  chk("retired", 32'(retired), 32'(me.ret));
               end
            end
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      m_valid      = 1'b0;
      m_wa3        = '0;
      m_reg_write  = 1'b0;
      m_mem_to_reg = 1'b0;
      m_alu_result = '0;
      mem_rvalid   = 1'b0;
      mem_rdata    = '0;
      model_ret    = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      rst_n = 1'b1;

      // Directed cases
      do_instr(4'd1, 1'b1, 1'b0, 32'd555, 0, 32'd0);
      idle(2);
      do_instr(4'd5, 1'b1, 1'b0, 32'h11, 0, 32'd0);
      do_instr(4'd7, 1'b1, 1'b0, 32'h22, 0, 32'd0);
      do_instr(4'd2, 1'b1, 1'b0, 32'h33, 0, 32'd0);
      idle(2);
      do_instr(4'd7, 1'b1, 1'b1, 32'h40, 2, 32'd666);
      do_instr(4'd3, 1'b1, 1'b1, 32'h44, 0, 32'hA5A5_0001);
      do_instr(4'd4, 1'b1, 1'b1, 32'h48, int'(T) - 1, 32'hBEEF_0002);
      do_instr(4'd6, 1'b1, 1'b1, 32'h4C, int'(T), 32'd0);
      do_instr(4'd15, 1'b1, 1'b0, 32'h100, 0, 32'd0);
      do_instr(4'd15, 1'b1, 1'b1, 32'h104, 1, 32'h0000_2000);
      do_instr(4'd9, 1'b0, 1'b0, 32'h123, 0, 32'd0);
      do_instr(4'd8, 1'b1, 1'b0, 32'hFFFF_FFFF, 0, 32'd0);
      idle(3);
      chk("retired_after_directed", 32'(retired), 32'(model_ret));

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         logic [3:0] wa3;
         wa3 = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
         do_instr(wa3, ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0),
                  $urandom, int'($urandom_range(0, T + 2)), $urandom);
      end
      idle(4);
      chk("retired_after_random", 32'(retired), 32'(model_ret));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a load, followed by stray read data
      @(negedge clk);
      m_valid      = 1'b1;
      m_wa3        = 4'd3;
      m_reg_write  = 1'b1;
      m_mem_to_reg = 1'b1;
      m_alu_result = 32'h80;
      mem_rvalid   = 1'b0;
      @(negedge clk);
      m_valid = 1'b0;
      chk("m_ready_before_reset", 32'(m_ready), 32'd0);
      @(negedge clk);
      rst_n     = 1'b0;
      model_ret = '0;
      #1;
      chk_reset_outputs();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mem_rvalid = 1'b0;
      idle(3);
      chk("retired_after_reset", 32'(retired), 32'd0);
      chk("WE3_after_reset", 32'(WE3), 32'd0);
      chk("m_ready_after_reset", 32'(m_ready), 32'd1);
      chk("queue_empty_end", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
